clock_group_reset_sequencer: RTL and testbench

//  Controller for the subsystem clock-group fan-out (sbus, pbus, fbus, mbus, cbus).

---
 rtl/clock_group_pkg.sv | 19 +
 rtl/clock_group_hold_counter.sv | 36 +++
 rtl/clock_group_reset_sequencer.sv | 118 +++++++++++
 tb/tb_clock_group_reset_sequencer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/clock_group_pkg.sv
// Shared types and constants for the clock-group reset sequencer.
package clock_group_pkg;

  localparam int unsigned NUM_CLOCK_GROUPS = 5;

  localparam int unsigned GRP_SBUS = 0;
  localparam int unsigned GRP_PBUS = 1;
  localparam int unsigned GRP_FBUS = 2;
  localparam int unsigned GRP_MBUS = 3;
  localparam int unsigned GRP_CBUS = 4;

  typedef enum logic [1:0] {
    ASSERT = 2'd0,
    WAIT   = 2'd1,
    SKIP   = 2'd2,
    DONE   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/clock_group_hold_counter.sv
// Hold-interval counter shared by the ASSERT and WAIT phases; flags the last cycle of a hold.
module clock_group_hold_counter #(
  parameter int unsigned HoldCycles = 16,
  parameter int unsigned CntW       = $clog2(HoldCycles + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            inc_i,
  output logic [CntW-1:0] cnt_o,
  output logic            tc_o
);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == CntW'(HoldCycles - 1));

endmodule

// File: rtl/clock_group_reset_sequencer.sv
// Releases per-group bus resets one at a time in index order with a fixed hold between
// releases; supports a software-triggered re-sequence once the sequence has completed.
module clock_group_reset_sequencer
  import clock_group_pkg::*;
#(
  parameter int unsigned NUM_GROUPS  = NUM_CLOCK_GROUPS,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_GROUPS-1:0] group_enable,
  input  logic                  sw_reset_req,
  output logic [NUM_GROUPS-1:0] group_reset_o,
  output logic                  busy,
  output logic                  all_released
);

  localparam int unsigned IdxW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

  seq_state_e            state_d, state_q;
  logic [IdxW-1:0]       idx_d, idx_q;
  logic [NUM_GROUPS-1:0] grp_rst_d, grp_rst_q;
  logic                  busy_d, busy_q;
  logic                  all_rel_d, all_rel_q;

  logic             cnt_clr, cnt_inc, cnt_tc;
  logic [CNT_W-1:0] cnt;
  logic             last_idx;

  clock_group_hold_counter #(
    .HoldCycles (HOLD_CYCLES),
    .CntW       (CNT_W)
  ) u_hold_cnt (
    .clk_i (clock),
    .rst_i (reset),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .cnt_o (cnt),
    .tc_o  (cnt_tc)
  );

  assign last_idx = (idx_q == IdxW'(NUM_GROUPS - 1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    grp_rst_d = grp_rst_q;
    busy_d    = busy_q;
    all_rel_d = all_rel_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state_q)
      ASSERT: begin
        if (cnt_tc) begin
          state_d = WAIT;
          idx_d   = '0;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WAIT, SKIP: begin
        // Enable is looked at only on the first cycle a group is selected (cnt == 0).
        if ((cnt == '0) && !group_enable[idx_q]) begin
          cnt_clr = 1'b1;
          state_d = SKIP;
        end else if (cnt_tc) begin
          grp_rst_d[idx_q] = 1'b0;
          cnt_clr          = 1'b1;
          state_d          = WAIT;
        end else begin
          cnt_inc = 1'b1;
        end
        if (cnt_clr) begin
          if (last_idx) begin
            state_d   = DONE;
            busy_d    = 1'b0;
            all_rel_d = 1'b1;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      DONE: begin
        if (sw_reset_req) begin
          state_d   = ASSERT;
          grp_rst_d = '1;
          busy_d    = 1'b1;
          all_rel_d = 1'b0;
          cnt_clr   = 1'b1;
        end
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= WAIT;
      idx_q     <= '0;
      grp_rst_q <= '1;
      busy_q    <= 1'b1;
      all_rel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      grp_rst_q <= grp_rst_d;
      busy_q    <= busy_d;
      all_rel_q <= all_rel_d;
    end
  end

  assign group_reset_o = grp_rst_q;
  assign busy          = busy_q;
  assign all_released  = all_rel_q;

endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// Bench for the clock-group reset sequencer: HOLD_CYCLES=4 and HOLD_CYCLES=1 instances
// checked edge by edge against a release-schedule model.
module tb_clock_group_reset_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst4, req4, busy4, ar4;
  logic [4:0] en4, grp4;
  logic       rst1, req1, busy1, ar1;
  logic [4:0] en1, grp1;

  int n_checks = 0;
  int n_fails  = 0;

  clock_group_reset_sequencer #(.NUM_GROUPS(5), .HOLD_CYCLES(4)) dut4 (
    .clock         (clock),
    .reset         (rst4),
    .group_enable  (en4),
    .sw_reset_req  (req4),
    .group_reset_o (grp4),
    .busy          (busy4),
    .all_released  (ar4)
  );

  clock_group_reset_sequencer #(.NUM_GROUPS(5), .HOLD_CYCLES(1)) dut1 (
    .clock         (clock),
    .reset         (rst1),
    .group_enable  (en1),
    .sw_reset_req  (req1),
    .group_reset_o (grp1),
    .busy          (busy1),
    .all_released  (ar1)
  );

  localparam logic [6:0] AllHeld = 7'b11111_1_0;

  // Release schedule: enabled group costs h edges and releases at its end; disabled costs 1.
  function automatic int seq_len(input int h, input logic [4:0] en);
    int t = 0;
    for (int k = 0; k < 5; k++) t += en[k] ? h : 1;
    return t;
  endfunction

  function automatic logic [6:0] model(input int h, input logic [4:0] en, input int m);
    logic [4:0] bits = 5'b11111;
    int t = 0;
    for (int k = 0; k < 5; k++) begin
      if (en[k]) begin
        t += h;
        if (m >= t) bits[k] = 1'b0;
      end else begin
        t += 1;
      end
    end
    return {bits, (m < t), (m >= t)};
  endfunction

  function automatic logic [6:0] obs(input int h);
    return (h == 1) ? {grp1, busy1, ar1} : {grp4, busy4, ar4};
  endfunction

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed {grp,busy,all}=%b required %b", tag, got, exp);
    end
  endtask

  task automatic set_req(input int h, input logic v);
    if (h == 1) req1 = v; else req4 = v;
  endtask

  task automatic set_en(input int h, input logic [4:0] v);
    if (h == 1) en1 = v; else en4 = v;
  endtask

  task automatic do_reset(input string tag, input int h);
    if (h == 1) rst1 = 1'b1; else rst4 = 1'b1;
    #3;
    check(tag, obs(h), AllHeld);
    @(negedge clock);
    if (h == 1) rst1 = 1'b0; else rst4 = 1'b0;
  endtask

  // Checks every edge from 1 to two past completion; pre = ASSERT-phase edges.
  task automatic seq_check(input string tag, input int h, input logic [4:0] en, input int pre,
                           input bit poke);
    int last = pre + seq_len(h, en) + 2;
    for (int n = 1; n <= last; n++) begin
      @(posedge clock);
      #1;
      check(tag, obs(h), (n <= pre) ? AllHeld : model(h, en, n - pre));
      if (poke && n == 2) set_req(h, 1'b1);
      if (poke && n == 3) set_req(h, 1'b0);
    end
  endtask

  // Called while in DONE, #1 after an edge; the next edge samples the request.
  task automatic resequence(input string tag, input int h, input logic [4:0] en, input bit poke);
    set_en(h, en);
    set_req(h, 1'b1);
    @(posedge clock);
    #1;
    set_req(h, 1'b0);
    check({tag, "_req_edge"}, obs(h), AllHeld);
    seq_check(tag, h, en, h, poke);
  endtask

  initial begin
    rst4 = 1'b1; req4 = 1'b0; en4 = 5'b11111;
    rst1 = 1'b1; req1 = 1'b0; en1 = 5'b11111;

    do_reset("s1_reset", 4);
    seq_check("s1_all_en", 4, 5'b11111, 0, 1'b0);

    en4 = 5'b11101;
    do_reset("s2_reset", 4);
    seq_check("s2_skip1", 4, 5'b11101, 0, 1'b0);

    resequence("s3_sw_req", 4, 5'b11111, 1'b0);

    en4 = 5'b11111;
    do_reset("s4_reset", 4);
    seq_check("s4_req_busy", 4, 5'b11111, 0, 1'b1);

    do_reset("s5_reset", 4);
    repeat (10) @(posedge clock);
    #3;
    rst4 = 1'b1;
    #1;
    check("s5_async", obs(4), AllHeld);
    @(negedge clock);
    rst4 = 1'b0;
    seq_check("s5_restart", 4, 5'b11111, 0, 1'b0);

    // Enable changes while in DONE must not disturb the completed state.
    en4 = 5'b00000;
    repeat (3) @(posedge clock);
    #1;
    check("done_en_change", obs(4), model(4, 5'b11111, 100));

    do_reset("s6_reset", 1);
    seq_check("s6_h1_all", 1, 5'b11111, 0, 1'b0);
    resequence("s6_h1_none", 1, 5'b00000, 1'b0);

    for (int i = 0; i < 6; i++) begin
      resequence("rnd_h4", 4, 5'($urandom), 1'($urandom));
      resequence("rnd_h1", 1, 5'($urandom), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
